// File: rtl/pdu_ctrl_if.sv
// Debug-controller bus: CPU run/step/dump requests, breakpoint, register-file read and dump stream.
// The master modport is the debugger/CPU side; the slave modport is pdu_ctrl.
interface pdu_ctrl_if;
    logic        run;
    logic        step;
    logic        dump;
    logic [31:0] pc;
    logic [31:0] brk_addr;
    logic        brk_valid;
    logic [31:0] rf_data;
    logic        dump_ready;
    logic        cpu_en;
    logic [7:0]  m_rf_addr;
    logic [31:0] dump_data;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [1:0]  state;
    logic [31:0] cyc_cnt;

    modport master (
        output run, step, dump, pc, brk_addr, brk_valid, rf_data, dump_ready,
        input  cpu_en, m_rf_addr, dump_data, dump_valid, dump_idx, state, cyc_cnt
    );

    modport slave (
        input  run, step, dump, pc, brk_addr, brk_valid, rf_data, dump_ready,
        output cpu_en, m_rf_addr, dump_data, dump_valid, dump_idx, state, cyc_cnt
    );
endinterface

// File: rtl/pdu_ctrl.sv
// CPU debug controller: halt/run/single-step, PC breakpoint and register-file dump stream.
// Define PDU_BREAKPOINT_EN to enable the breakpoint; otherwise brk_addr/brk_valid are ignored.
module pdu_ctrl #(
    parameter int RF_WORDS = 32,
    parameter int SETTLE   = 1
) (
    input  logic      clk,
    input  logic      rst,
    pdu_ctrl_if.slave pdu_io
);
    localparam logic [1:0] HALT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] DUMP = 2'd3;

    localparam logic [4:0] LAST_IDX    = 5'(RF_WORDS - 1);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    logic [1:0]  state_q, state_d;
    logic [4:0]  dumpIdx_q, dumpIdx_d;
    logic [2:0]  settleCnt_q, settleCnt_d;
    logic [31:0] dumpData_q, dumpData_d;
    logic        dumpValid_q, dumpValid_d;
    logic        resumeMask_q, resumeMask_d;
    logic [31:0] cycCnt_q;
    logic        stepPrev_q, stepArm_q;
    logic        dumpPrev_q, dumpArm_q;
    logic        stepEdge, dumpEdge;
    logic        bpHit;
    logic        cpuEn;

    // An input must be seen low after reset before its rising edge counts as an event.
    assign stepEdge = pdu_io.step & ~stepPrev_q & stepArm_q;
    assign dumpEdge = pdu_io.dump & ~dumpPrev_q & dumpArm_q;

`ifdef PDU_BREAKPOINT_EN
    assign bpHit = pdu_io.brk_valid && (pdu_io.pc == pdu_io.brk_addr) && !resumeMask_q;
`else
    logic unusedBrk;
    assign unusedBrk = ^{pdu_io.brk_addr, pdu_io.brk_valid, resumeMask_q};
    assign bpHit     = 1'b0;
`endif

    assign cpuEn = ((state_q == RUN) && !bpHit) || (state_q == STEP);

    always_comb begin
        state_d      = state_q;
        dumpIdx_d    = dumpIdx_q;
        settleCnt_d  = settleCnt_q;
        dumpData_d   = dumpData_q;
        dumpValid_d  = dumpValid_q;
        resumeMask_d = resumeMask_q;
        case (state_q)
            HALT: begin
                dumpIdx_d   = 5'd0;
                settleCnt_d = 3'd0;
                dumpValid_d = 1'b0;
                if (dumpEdge) begin
                    state_d = DUMP;
                end else if (stepEdge) begin
                    state_d = STEP;
                end else if (pdu_io.run) begin
                    state_d      = RUN;
                    resumeMask_d = 1'b1;
                end
            end
            RUN: begin
                resumeMask_d = 1'b0;
                if (!pdu_io.run || bpHit) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                state_d = HALT;
            end
            DUMP: begin
                // A word is presented only after its address has been stable for SETTLE cycles.
                if (dumpValid_q) begin
                    if (pdu_io.dump_ready) begin
                        dumpValid_d = 1'b0;
                        settleCnt_d = 3'd0;
                        if (dumpIdx_q == LAST_IDX) begin
                            state_d   = HALT;
                            dumpIdx_d = 5'd0;
                        end else begin
                            dumpIdx_d = dumpIdx_q + 5'd1;
                        end
                    end
                end else if (settleCnt_q == SETTLE_LAST) begin
                    dumpData_d  = pdu_io.rf_data;
                    dumpValid_d = 1'b1;
                end else begin
                    settleCnt_d = settleCnt_q + 3'd1;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HALT;
            dumpIdx_q    <= 5'd0;
            settleCnt_q  <= 3'd0;
            dumpData_q   <= 32'd0;
            dumpValid_q  <= 1'b0;
            resumeMask_q <= 1'b0;
            cycCnt_q     <= 32'd0;
            stepPrev_q   <= 1'b0;
            stepArm_q    <= 1'b0;
            dumpPrev_q   <= 1'b0;
            dumpArm_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dumpIdx_q    <= dumpIdx_d;
            settleCnt_q  <= settleCnt_d;
            dumpData_q   <= dumpData_d;
            dumpValid_q  <= dumpValid_d;
            resumeMask_q <= resumeMask_d;
            stepPrev_q   <= pdu_io.step;
            stepArm_q    <= stepArm_q | ~pdu_io.step;
            dumpPrev_q   <= pdu_io.dump;
            dumpArm_q    <= dumpArm_q | ~pdu_io.dump;
            if (cpuEn) begin
                cycCnt_q <= cycCnt_q + 32'd1;
            end
        end
    end

    assign pdu_io.cpu_en     = cpuEn;
    assign pdu_io.m_rf_addr  = {3'b000, dumpIdx_q};
    assign pdu_io.dump_data  = dumpData_q;
    assign pdu_io.dump_valid = dumpValid_q;
    assign pdu_io.dump_idx   = dumpIdx_q;
    assign pdu_io.state      = state_q;
    assign pdu_io.cyc_cnt    = cycCnt_q;
endmodule

// File: tb/tb_pdu_ctrl.sv
// Directed testbench for pdu_ctrl: run/step counts, breakpoint stop and resume, dump stream,
// back-pressure, reset mid-dump and held-input edge suppression after reset.
module tb_pdu_ctrl;
    localparam logic [1:0] HALT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DUMP = 2'd3;

`ifdef PDU_BREAKPOINT_EN
    localparam logic [31:0] EXP_BP_EN    = 32'd0;
    localparam logic [31:0] EXP_BP_STATE = 32'd0;
    localparam logic [31:0] EXP_BP_PC    = 32'h2C;
    localparam logic [31:0] EXP_BP_CYC   = 32'd18;
`else
    localparam logic [31:0] EXP_BP_EN    = 32'd1;
    localparam logic [31:0] EXP_BP_STATE = 32'd1;
    localparam logic [31:0] EXP_BP_PC    = 32'h34;
    localparam logic [31:0] EXP_BP_CYC   = 32'd20;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pdu_ctrl_if bus ();

    pdu_ctrl #(
        .RF_WORDS(32),
        .SETTLE  (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pdu_io(bus.slave)
    );

    // Register file model: each word reads back as 0x100 plus its address.
    assign bus.rf_data = 32'h0000_0100 + {24'd0, bus.m_rf_addr};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic runV, input logic stepV, input logic dumpV, input logic readyV);
        bus.run        = runV;
        bus.step       = stepV;
        bus.dump       = dumpV;
        bus.dump_ready = readyV;
    endtask

    initial begin
        int  enCount;
        int  expIdx;
        int  nonHalt;
        bit  seen;
        bit  held;
        bit  reached9;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        bus.pc        = 32'd0;
        bus.brk_addr  = 32'd0;
        bus.brk_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstState", bus.state, HALT);
        checkOutput("rstCpuEn", bus.cpu_en, 0);
        checkOutput("rstCycCnt", bus.cyc_cnt, 0);
        checkOutput("rstValid", bus.dump_valid, 0);
        checkOutput("rstIdx", bus.dump_idx, 0);
        checkOutput("rstAddr", bus.m_rf_addr, 0);
        checkOutput("rstData", bus.dump_data, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] free run for 10 cycles");
        enCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bus.cpu_en) enCount++;
            if (i == 10) bus.run = 1'b0;
        end
        checkOutput("runEnCount", enCount, 10);
        checkOutput("runState", bus.state, HALT);
        checkOutput("runCycCnt", bus.cyc_cnt, 10);

        $display("[TB] step held for 5 cycles");
        enCount = 0;
        bus.step = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.cpu_en) enCount++;
            if (i == 5) bus.step = 1'b0;
        end
        checkOutput("stepEnCount", enCount, 1);
        checkOutput("stepCycCnt", bus.cyc_cnt, 11);
        checkOutput("stepState", bus.state, HALT);

        $display("[TB] breakpoint at 0x1C");
        bus.pc        = 32'h10;
        bus.brk_addr  = 32'h1C;
        bus.brk_valid = 1'b1;
        bus.run       = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.state == RUN && bus.pc == 32'h1C) begin
                seen = 1'b1;
                checkOutput("bpCpuEn", bus.cpu_en, EXP_BP_EN);
            end
            if (bus.cpu_en) bus.pc = bus.pc + 32'd4;
        end
        checkOutput("bpReached", seen, 1);
        @(negedge clk);
        checkOutput("bpState", bus.state, EXP_BP_STATE);
        if (bus.cpu_en) bus.pc = bus.pc + 32'd4;
        bus.run = 1'b0;
        @(negedge clk);
        if (bus.cpu_en) bus.pc = bus.pc + 32'd4;
        bus.run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cpu_en) bus.pc = bus.pc + 32'd4;
        end
        checkOutput("bpResumePc", bus.pc, EXP_BP_PC);
        bus.run       = 1'b0;
        bus.brk_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.cpu_en) bus.pc = bus.pc + 32'd4;
        end
        checkOutput("bpHaltState", bus.state, HALT);
        checkOutput("bpCycCnt", bus.cyc_cnt, EXP_BP_CYC);

        $display("[TB] full dump with dump_ready high");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("dumpEnter", bus.state, DUMP);
        checkOutput("dumpCpuEn", bus.cpu_en, 0);
        expIdx = 0;
        for (int c = 0; c < 200 && expIdx < 32; c++) begin
            if (bus.dump_valid) begin
                checkOutput($sformatf("dumpData%0d", expIdx), bus.dump_data, 32'h100 + expIdx);
                checkOutput($sformatf("dumpIdx%0d", expIdx), bus.dump_idx, expIdx);
                expIdx++;
            end
            @(negedge clk);
        end
        checkOutput("dumpWords", expIdx, 32);
        checkOutput("dumpDoneState", bus.state, HALT);
        checkOutput("dumpDoneAddr", bus.m_rf_addr, 0);
        checkOutput("dumpDoneValid", bus.dump_valid, 0);

        $display("[TB] dump with back-pressure and reset mid-dump");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("dumpBeatsStep", bus.state, DUMP);
        held     = 1'b0;
        reached9 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.dump_idx == 5'd9) begin
                reached9 = 1'b1;
                break;
            end
            if (bus.dump_valid && bus.dump_idx == 5'd5 && !held) begin
                bus.dump_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("holdData", bus.dump_data, 32'h105);
                    checkOutput("holdValid", bus.dump_valid, 1);
                end
                held = 1'b1;
                bus.dump_ready = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("holdSeen", held, 1);
        checkOutput("reachIdx9", reached9, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstValid", bus.dump_valid, 0);
        checkOutput("midRstState", bus.state, HALT);
        checkOutput("midRstIdx", bus.dump_idx, 0);
        checkOutput("midRstData", bus.dump_data, 0);
        checkOutput("midRstCyc", bus.cyc_cnt, 0);
        rst = 1'b0;

        $display("[TB] step and dump held across reset release");
        enCount = 0;
        nonHalt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.cpu_en) enCount++;
            if (bus.state != HALT) nonHalt++;
        end
        checkOutput("heldNoEn", enCount, 0);
        checkOutput("heldNoEvent", nonHalt, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.step = 1'b1;
        enCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cpu_en) enCount++;
        end
        checkOutput("reStepEn", enCount, 1);
        checkOutput("reStepCyc", bus.cyc_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pdu_ctrl.md
PDU_CTRL -- requirements
Module: pdu_ctrl

Interface
REQ-001 Parameter RF_WORDS, default 32; number of register-file words walked by a dump (1..32).
REQ-002 Parameter SETTLE, default 1; cycles to wait after m_rf_addr changes before sampling rf_data (1..7).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 run  in  1  level; request free-running CPU execution.
REQ-006 step  in  1  rising edge requests one CPU cycle.
REQ-007 dump  in  1  rising edge requests a register-file dump.
REQ-008 pc  in  32  current CPU fetch PC.
REQ-009 brk_addr  in  32  breakpoint PC.
REQ-010 brk_valid  in  1  breakpoint armed.
REQ-011 rf_data  in  32  CPU debug register read data for m_rf_addr.
REQ-012 dump_ready  in  1  consumer accepts dump word.
REQ-013 cpu_en  out  1  CPU clock enable, combinational from state.
REQ-014 m_rf_addr  out  8  CPU debug register address; upper 3 bits always 0.
REQ-015 dump_data  out  32  captured register word.
REQ-016 dump_valid  out  1  dump_data valid.
REQ-017 dump_idx  out  5  index of the word on dump_data.
REQ-018 state  out  2  HALT=0, RUN=1, STEP=2, DUMP=3.
REQ-019 cyc_cnt  out  32  count of cycles with cpu_en=1, wraps 0xFFFFFFFF->0.

Function
REQ-020 step and dump SHALL be edge-detected with one registered copy each; a held level SHALL produce one event.
REQ-021 HALT: dump edge->DUMP; else step edge->STEP; else run=1->RUN (dump beats step beats run).
REQ-022 RUN: cpu_en=1 unless bp_hit; run=0 or bp_hit->HALT next cycle; step and dump edges ignored.
REQ-023 bp_hit = brk_valid AND pc==brk_addr AND NOT resume_mask; cpu_en SHALL be 0 in the bp_hit cycle, so the instruction at brk_addr is not clocked.
REQ-024 resume_mask SHALL set on every HALT->RUN transition and clear after the first RUN cycle, allowing resume from a breakpoint PC.
REQ-025 STEP: cpu_en=1 for exactly one cycle, then HALT; breakpoints ignored.
REQ-026 DUMP: cpu_en=0; idx starts 0; m_rf_addr=idx; after SETTLE cycles rf_data SHALL be captured into dump_data and dump_valid set.
REQ-027 dump_valid and dump_data SHALL hold stable until dump_ready=1 in a cycle with dump_valid=1 (transfer).
REQ-028 After a transfer dump_valid SHALL drop for at least SETTLE cycles; idx increments; transfer of idx=RF_WORDS-1 -> HALT, m_rf_addr=0.
REQ-029 dump_ready while dump_valid=0 SHALL have no effect.
REQ-030 cyc_cnt SHALL increment in every cycle with cpu_en=1.

Reset
REQ-031 rst=1 SHALL force state=HALT, cpu_en=0, m_rf_addr=0, dump_data=0, dump_valid=0, dump_idx=0, cyc_cnt=0, resume_mask=0, edge registers=0, from any state including mid-dump.
REQ-032 After rst deasserts, a step or dump held high SHALL NOT create an event until it falls and rises again.

Configuration
REQ-033 Macro PDU_BREAKPOINT_EN: defined -> REQ-023/024 apply; undefined -> bp_hit constant 0, brk_addr/brk_valid ignored, ports retained.

Verification
REQ-034 rst 2 cycles, run=1 for 10 cycles then run=0 -> cpu_en=1 for 10 cycles, state=HALT, cyc_cnt=10.
REQ-035 HALT, step pulse held 5 cycles -> cpu_en=1 exactly one cycle, cyc_cnt+1, state back to HALT.
REQ-036 brk_addr=0x0000001C, brk_valid=1, run=1, pc reaches 0x1C -> cpu_en=0 that cycle, state=HALT; run toggled 0->1 -> execution resumes past 0x1C.
REQ-037 dump edge, rf_data=0x100+addr, dump_ready=1 -> 32 words 0x100..0x11F, dump_idx 0..31, then HALT.
REQ-038 dump with dump_ready=0 for 4 cycles at idx=5 -> dump_data=0x105 held stable; rst asserted at idx=9 -> dump_valid=0, state=HALT next cycle.
